// File: rtl/point_add.sv
// Affine elliptic-curve point adder R = P + Q over GF(PRIME) on y^2 = x^3 + CURVE_A*x + b.
// Uses one shared shift-add modular multiplier and a binary extended-Euclid inverse.
//   state    | meaning
//   S_LOAD   | capture P and Q
//   S_CHECK  | pick identity / inverse / doubling / general case
//   S_NUMDEN | form lambda numerator and denominator
//   S_INVERT | invert denominator (binary extended Euclid)
//   S_LAMBDA | lambda = num * den^-1
//   S_RX     | Rx = lambda^2 - Px - Qx
//   S_RY     | Ry = lambda*(Px - Rx) - Py
//   S_DONE   | commit R and Done, hold until Reset
module point_add #(
  parameter int unsigned        P_WIDTH = 256,
  parameter logic [P_WIDTH-1:0] PRIME   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter logic [P_WIDTH-1:0] CURVE_A = '0
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [2*P_WIDTH-1:0]   P,
  input  logic [2*P_WIDTH-1:0]   Q,
  output logic [2*P_WIDTH-1:0]   R,
  output logic                   Done
);

  typedef logic [P_WIDTH-1:0] fe_t;
  localparam int unsigned CW = $clog2(P_WIDTH + 1);

  typedef enum logic [2:0] {
    S_LOAD, S_CHECK, S_NUMDEN, S_INVERT, S_LAMBDA, S_RX, S_RY, S_DONE
  } state_t;

  function automatic fe_t mod_add(input fe_t a, input fe_t b);
    logic [P_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
    return s[P_WIDTH-1:0];
  endfunction

  function automatic fe_t mod_sub(input fe_t a, input fe_t b);
    return (a >= b) ? (a - b) : (a - b + PRIME);
  endfunction

  // x/2 mod PRIME: odd values borrow one PRIME so the shift is exact
  function automatic fe_t mod_half(input fe_t a);
    logic [P_WIDTH:0] s;
    s = a[0] ? ({1'b0, a} + {1'b0, PRIME}) : {1'b0, a};
    return s[P_WIDTH:1];
  endfunction

  state_t state_q, state_d;
  fe_t    px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  fe_t    num_q, num_d, inv_q, inv_d, lam_q, lam_d, rx_q, rx_d, ry_q, ry_d;
  fe_t    u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  logic   dbl_q, dbl_d, wait_q, wait_d, done_q, done_d;
  logic [2*P_WIDTH-1:0] r_q, r_d;

  fe_t            m_acc_q, m_acc_d, m_a_q, m_a_d, m_b_q, m_b_d, m_step;
  logic [CW-1:0]  m_cnt_q, m_cnt_d;
  logic           m_busy_q, m_busy_d;
  logic           mul_start, mul_done;
  fe_t            mul_a, mul_b;

  // interleaved multiplier: MSB-first, acc = 2*acc (+a), P_WIDTH+2 cycles per product
  always_comb begin
    m_acc_d  = m_acc_q;
    m_a_d    = m_a_q;
    m_b_d    = m_b_q;
    m_cnt_d  = m_cnt_q;
    m_busy_d = m_busy_q;
    m_step   = mod_add(m_acc_q, m_acc_q);
    if (m_b_q[P_WIDTH-1]) m_step = mod_add(m_step, m_a_q);
    if (mul_start) begin
      m_acc_d  = '0;
      m_a_d    = mul_a;
      m_b_d    = mul_b;
      m_cnt_d  = CW'(P_WIDTH);
      m_busy_d = 1'b1;
    end else if (m_busy_q) begin
      if (m_cnt_q != '0) begin
        m_acc_d = m_step;
        m_b_d   = m_b_q << 1;
        m_cnt_d = m_cnt_q - 1'b1;
      end else begin
        m_busy_d = 1'b0;
      end
    end
  end

  assign mul_done = m_busy_q && (m_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    px_d = px_q;  py_d = py_q;  qx_d = qx_q;  qy_d = qy_q;
    num_d = num_q;  inv_d = inv_q;  lam_d = lam_q;  rx_d = rx_q;  ry_d = ry_q;
    u_d = u_q;  v_d = v_q;  x1_d = x1_q;  x2_d = x2_q;
    dbl_d     = dbl_q;
    wait_d    = wait_q;
    done_d    = done_q;
    r_d       = r_q;
    mul_start = 1'b0;
    mul_a     = px_q;
    mul_b     = px_q;
    case (state_q)
      S_LOAD: begin
        px_d    = P[2*P_WIDTH-1:P_WIDTH];
        py_d    = P[P_WIDTH-1:0];
        qx_d    = Q[2*P_WIDTH-1:P_WIDTH];
        qy_d    = Q[P_WIDTH-1:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (px_q == '0 && py_q == '0) begin
          rx_d = qx_q;  ry_d = qy_q;  state_d = S_DONE;
        end else if (qx_q == '0 && qy_q == '0) begin
          rx_d = px_q;  ry_d = py_q;  state_d = S_DONE;
        end else if (px_q == qx_q && mod_add(py_q, qy_q) == '0) begin
          rx_d = '0;  ry_d = '0;  state_d = S_DONE;
        end else begin
          dbl_d   = (px_q == qx_q);
          state_d = S_NUMDEN;
        end
      end
      S_NUMDEN: begin
        v_d  = PRIME;
        x1_d = fe_t'(1);
        x2_d = '0;
        if (!dbl_q) begin
          num_d   = mod_sub(qy_q, py_q);
          u_d     = mod_sub(qx_q, px_q);
          state_d = S_INVERT;
        end else if (!wait_q) begin
          mul_start = 1'b1;
          wait_d    = 1'b1;
        end else if (mul_done) begin
          num_d   = mod_add(mod_add(mod_add(m_acc_q, m_acc_q), m_acc_q), CURVE_A);
          u_d     = mod_add(py_q, py_q);
          wait_d  = 1'b0;
          state_d = S_INVERT;
        end
      end
      S_INVERT: begin
        // invariant: x1*den == u, x2*den == v (mod PRIME); u*v at least halves per cycle
        if (u_q == fe_t'(1)) begin
          inv_d = x1_q;  state_d = S_LAMBDA;
        end else if (v_q == fe_t'(1)) begin
          inv_d = x2_q;  state_d = S_LAMBDA;
        end else if (u_q == '0) begin
          inv_d = '0;  state_d = S_LAMBDA;
        end else if (!u_q[0]) begin
          u_d = u_q >> 1;  x1_d = mod_half(x1_q);
        end else if (!v_q[0]) begin
          v_d = v_q >> 1;  x2_d = mod_half(x2_q);
        end else if (u_q >= v_q) begin
          u_d = (u_q - v_q) >> 1;  x1_d = mod_half(mod_sub(x1_q, x2_q));
        end else begin
          v_d = (v_q - u_q) >> 1;  x2_d = mod_half(mod_sub(x2_q, x1_q));
        end
      end
      S_LAMBDA: begin
        mul_a = num_q;
        mul_b = inv_q;
        if (!wait_q) begin
          mul_start = 1'b1;  wait_d = 1'b1;
        end else if (mul_done) begin
          lam_d = m_acc_q;  wait_d = 1'b0;  state_d = S_RX;
        end
      end
      S_RX: begin
        mul_a = lam_q;
        mul_b = lam_q;
        if (!wait_q) begin
          mul_start = 1'b1;  wait_d = 1'b1;
        end else if (mul_done) begin
          rx_d = mod_sub(mod_sub(m_acc_q, px_q), qx_q);  wait_d = 1'b0;  state_d = S_RY;
        end
      end
      S_RY: begin
        mul_a = lam_q;
        mul_b = mod_sub(px_q, rx_q);
        if (!wait_q) begin
          mul_start = 1'b1;  wait_d = 1'b1;
        end else if (mul_done) begin
          ry_d = mod_sub(m_acc_q, py_q);  wait_d = 1'b0;  state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!done_q) begin
          r_d    = {rx_q, ry_q};
          done_d = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_LOAD;
      px_q <= '0;  py_q <= '0;  qx_q <= '0;  qy_q <= '0;
      num_q <= '0;  inv_q <= '0;  lam_q <= '0;  rx_q <= '0;  ry_q <= '0;
      u_q <= '0;  v_q <= '0;  x1_q <= '0;  x2_q <= '0;
      dbl_q <= 1'b0;  wait_q <= 1'b0;  done_q <= 1'b0;
      r_q <= '0;
      m_acc_q <= '0;  m_a_q <= '0;  m_b_q <= '0;  m_cnt_q <= '0;  m_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q <= px_d;  py_q <= py_d;  qx_q <= qx_d;  qy_q <= qy_d;
      num_q <= num_d;  inv_q <= inv_d;  lam_q <= lam_d;  rx_q <= rx_d;  ry_q <= ry_d;
      u_q <= u_d;  v_q <= v_d;  x1_q <= x1_d;  x2_q <= x2_d;
      dbl_q <= dbl_d;  wait_q <= wait_d;  done_q <= done_d;
      r_q <= r_d;
      m_acc_q <= m_acc_d;  m_a_q <= m_a_d;  m_b_q <= m_b_d;  m_cnt_q <= m_cnt_d;  m_busy_q <= m_busy_d;
    end
  end

  assign R    = r_q;
  assign Done = done_q;

endmodule

// File: tb/tb_point_add.sv
// Bench for point_add: small curve (p=17, a=2) and secp256k1, against a modular-arithmetic model.
module tb_point_add;
  typedef bit [255:0] u256;

  localparam u256 P_SMALL = 256'd17;
  localparam u256 A_SMALL = 256'd2;
  localparam u256 P_BIG   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam u256 GX      = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam u256 GY      = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam u256 G3X     = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
  localparam u256 G3Y     = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
  localparam int  BOUND_S = 8*8 + 32;
  localparam int  BOUND_B = 8*256 + 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s, rst_b, done_s, done_b;
  logic [15:0]  p_s, q_s, r_s;
  logic [511:0] p_b, q_b, r_b;
  int checks = 0;
  int failures = 0;

  point_add #(.P_WIDTH(8), .PRIME(8'd17), .CURVE_A(8'd2)) dut_s (
    .clk(clk), .Reset(rst_s), .P(p_s), .Q(q_s), .R(r_s), .Done(done_s));

  point_add dut_b (
    .clk(clk), .Reset(rst_b), .P(p_b), .Q(q_b), .R(r_b), .Done(done_b));

  function automatic u256 f_add(input u256 a, input u256 b, input u256 m);
    bit [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, m};
    return s[255:0];
  endfunction

  function automatic u256 f_sub(input u256 a, input u256 b, input u256 m);
    bit [256:0] s;
    s = ({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m};
    return s[255:0];
  endfunction

  function automatic u256 f_mul(input u256 a, input u256 b, input u256 m);
    bit [511:0] t;
    t = ({256'b0, a} * {256'b0, b}) % {256'b0, m};
    return t[255:0];
  endfunction

  function automatic u256 f_inv(input u256 a, input u256 m);
    u256 r, e;
    r = u256'(1);
    e = m - u256'(2);
    for (int i = 255; i >= 0; i--) begin
      r = f_mul(r, r, m);
      if (e[i]) r = f_mul(r, a, m);
    end
    return r;
  endfunction

  task automatic model_add(input u256 m, input u256 ca, input u256 px, input u256 py,
                           input u256 qx, input u256 qy, output u256 rx, output u256 ry);
    u256 lam;
    if (px == 0 && py == 0) begin
      rx = qx;  ry = qy;
    end else if (qx == 0 && qy == 0) begin
      rx = px;  ry = py;
    end else if (px == qx && f_add(py, qy, m) == 0) begin
      rx = 0;  ry = 0;
    end else begin
      if (px == qx)
        lam = f_mul(f_add(f_mul(u256'(3), f_mul(px, px, m), m), ca, m),
                    f_inv(f_mul(u256'(2), py, m), m), m);
      else
        lam = f_mul(f_sub(qy, py, m), f_inv(f_sub(qx, px, m), m), m);
      rx = f_sub(f_sub(f_mul(lam, lam, m), px, m), qx, m);
      ry = f_sub(f_mul(lam, f_sub(px, rx, m), m), py, m);
    end
  endtask

  function automatic bit is_ident(input u256 m, input u256 px, input u256 py, input u256 qx, input u256 qy);
    return (px == 0 && py == 0) || (qx == 0 && qy == 0) || (px == qx && f_add(py, qy, m) == 0);
  endfunction

  task automatic run_small(input u256 px, input u256 py, input u256 qx, input u256 qy,
                           output u256 rx, output u256 ry, output int lat, output bit seen);
    @(negedge clk);
    rst_s = 1'b0;
    p_s = {px[7:0], py[7:0]};
    q_s = {qx[7:0], qy[7:0]};
    @(negedge clk);
    rst_s = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < BOUND_S + 16) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        p_s = 16'($urandom);
        q_s = 16'($urandom);
      end
      if (done_s === 1'b1) seen = 1'b1;
    end
    rx = u256'(r_s[15:8]);
    ry = u256'(r_s[7:0]);
  endtask

  task automatic run_big(input u256 px, input u256 py, input u256 qx, input u256 qy,
                         output u256 rx, output u256 ry, output int lat, output bit seen);
    @(negedge clk);
    rst_b = 1'b0;
    p_b = {px, py};
    q_b = {qx, qy};
    @(negedge clk);
    rst_b = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < BOUND_B + 16) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        p_b = {16{32'($urandom)}};
        q_b = {16{32'($urandom)}};
      end
      if (done_b === 1'b1) seen = 1'b1;
    end
    rx = r_b[511:256];
    ry = r_b[255:0];
  endtask

  task automatic test_reset();
    rst_s = 1'b0;  rst_b = 1'b0;
    p_s = 16'h0501;  q_s = 16'h0603;
    p_b = {GX, GY};  q_b = {GX, GY};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (r_s !== 16'h0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_small R=%h Done=%b expected R=0 Done=0", r_s, done_s);
    end
    checks++;
    if (r_b !== 512'h0 || done_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_big R=%h Done=%b expected R=0 Done=0", r_b, done_b);
    end
  endtask

  task automatic test_general_add();
    u256 rx, ry;
    int lat;
    bit seen;
    run_small(5, 1, 6, 3, rx, ry, lat, seen);
    checks++;
    if (!seen || lat > BOUND_S) begin
      failures++;
      $display("FAIL add_latency got %0d cycles (done=%b) limit %0d", lat, seen, BOUND_S);
    end
    checks++;
    if (rx !== u256'(10) || ry !== u256'(6)) begin
      failures++;
      $display("FAIL add_result got (%0d,%0d) expected (10,6)", rx, ry);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_s !== 1'b1 || r_s !== {8'd10, 8'd6}) begin
      failures++;
      $display("FAIL add_hold got R=%h Done=%b expected R=0a06 Done=1", r_s, done_s);
    end
    #2;
    rst_s = 1'b0;
    #1;
    checks++;
    if (done_s !== 1'b0 || r_s !== 16'h0) begin
      failures++;
      $display("FAIL async_clear got R=%h Done=%b expected R=0 Done=0", r_s, done_s);
    end
  endtask

  task automatic test_doubling();
    u256 rx, ry;
    int lat;
    bit seen;
    run_small(5, 1, 5, 1, rx, ry, lat, seen);
    checks++;
    if (!seen || lat > BOUND_S || rx !== u256'(6) || ry !== u256'(3)) begin
      failures++;
      $display("FAIL double_51 got (%0d,%0d) lat=%0d done=%b expected (6,3)", rx, ry, lat, seen);
    end
    run_small(6, 3, 6, 3, rx, ry, lat, seen);
    checks++;
    if (!seen || lat > BOUND_S || rx !== u256'(3) || ry !== u256'(1)) begin
      failures++;
      $display("FAIL double_63 got (%0d,%0d) lat=%0d done=%b expected (3,1)", rx, ry, lat, seen);
    end
  endtask

  task automatic test_inverse_identity();
    u256 rx, ry;
    int lat;
    bit seen;
    run_small(5, 1, 5, 16, rx, ry, lat, seen);
    checks++;
    if (rx !== u256'(0) || ry !== u256'(0) || lat !== 3 || !seen) begin
      failures++;
      $display("FAIL inverse_pts got (%0d,%0d) lat=%0d expected (0,0) lat=3", rx, ry, lat);
    end
    run_small(0, 0, 10, 6, rx, ry, lat, seen);
    checks++;
    if (rx !== u256'(10) || ry !== u256'(6) || lat !== 3 || !seen) begin
      failures++;
      $display("FAIL ident_p got (%0d,%0d) lat=%0d expected (10,6) lat=3", rx, ry, lat);
    end
    run_small(10, 6, 0, 0, rx, ry, lat, seen);
    checks++;
    if (rx !== u256'(10) || ry !== u256'(6) || lat !== 3 || !seen) begin
      failures++;
      $display("FAIL ident_q got (%0d,%0d) lat=%0d expected (10,6) lat=3", rx, ry, lat);
    end
  endtask

  task automatic test_reset_midop();
    u256 rx, ry;
    int lat;
    bit seen;
    @(negedge clk);
    rst_s = 1'b0;
    p_s = {8'd5, 8'd1};
    q_s = {8'd6, 8'd3};
    @(negedge clk);
    rst_s = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_s = 1'b0;
    #1;
    checks++;
    if (r_s !== 16'h0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL midop_abort got R=%h Done=%b expected R=0 Done=0", r_s, done_s);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (r_s !== 16'h0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL midop_held got R=%h Done=%b expected R=0 Done=0", r_s, done_s);
    end
    run_small(6, 3, 5, 1, rx, ry, lat, seen);
    checks++;
    if (!seen || lat > BOUND_S || rx !== u256'(10) || ry !== u256'(6)) begin
      failures++;
      $display("FAIL midop_restart got (%0d,%0d) lat=%0d expected (10,6)", rx, ry, lat);
    end
  endtask

  task automatic test_random_small();
    u256 xs[$], ys[$];
    u256 px, py, qx, qy, ex, ey, rx, ry;
    int i, j, mode, lat;
    bit seen, ident;
    for (int x = 0; x < 17; x++)
      for (int y = 0; y < 17; y++)
        if ((y * y) % 17 == (x * x * x + 2 * x + 2) % 17) begin
          xs.push_back(u256'(x));
          ys.push_back(u256'(y));
        end
    xs.push_back(u256'(0));
    ys.push_back(u256'(0));
    for (int n = 0; n < 40; n++) begin
      i = int'($urandom_range(0, xs.size() - 1));
      j = int'($urandom_range(0, xs.size() - 1));
      mode = int'($urandom_range(0, 5));
      px = xs[i];  py = ys[i];
      if (mode == 0) begin
        qx = px;  qy = py;
      end else if (mode == 1) begin
        qx = px;  qy = (py == 0) ? u256'(0) : P_SMALL - py;
      end else begin
        qx = xs[j];  qy = ys[j];
      end
      model_add(P_SMALL, A_SMALL, px, py, qx, qy, ex, ey);
      ident = is_ident(P_SMALL, px, py, qx, qy);
      run_small(px, py, qx, qy, rx, ry, lat, seen);
      checks++;
      if (!seen || (ident && lat != 3) || lat > BOUND_S) begin
        failures++;
        $display("FAIL rand_small_lat n=%0d got lat=%0d done=%b expected %s", n, lat, seen,
                 ident ? "3" : "within bound");
      end
      checks++;
      if (rx !== ex || ry !== ey) begin
        failures++;
        $display("FAIL rand_small n=%0d (%0d,%0d)+(%0d,%0d) got (%0d,%0d) expected (%0d,%0d)",
                 n, px, py, qx, qy, rx, ry, ex, ey);
      end
    end
  endtask

  task automatic test_secp_fixed();
    u256 g2x, g2y, rx, ry;
    int lat;
    bit seen;
    model_add(P_BIG, 0, GX, GY, GX, GY, g2x, g2y);
    run_big(GX, GY, GX, GY, rx, ry, lat, seen);
    checks++;
    if (!seen || lat > BOUND_B || rx !== g2x || ry !== g2y) begin
      failures++;
      $display("FAIL secp_2g lat=%0d got %h,%h expected %h,%h", lat, rx, ry, g2x, g2y);
    end
    run_big(GX, GY, g2x, g2y, rx, ry, lat, seen);
    checks++;
    if (!seen || lat > BOUND_B || rx !== G3X || ry !== G3Y) begin
      failures++;
      $display("FAIL secp_3g lat=%0d got %h,%h expected %h,%h", lat, rx, ry, G3X, G3Y);
    end
  endtask

  task automatic test_secp_random();
    u256 mx[$], my[$];
    u256 nx, ny, px, py, qx, qy, ex, ey, rx, ry;
    int i, j, mode, lat;
    bit seen, ident;
    mx.push_back(GX);
    my.push_back(GY);
    for (int k = 1; k < 8; k++) begin
      model_add(P_BIG, 0, mx[k-1], my[k-1], GX, GY, nx, ny);
      mx.push_back(nx);
      my.push_back(ny);
    end
    for (int n = 0; n < 20; n++) begin
      i = int'($urandom_range(0, 7));
      j = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 6));
      px = mx[i];  py = my[i];
      qx = mx[j];  qy = my[j];
      if (mode == 0) begin
        qx = px;  qy = P_BIG - py;
      end else if (mode == 1) begin
        qx = px;  qy = py;
      end else if (mode == 2) begin
        px = 0;  py = 0;
      end
      model_add(P_BIG, 0, px, py, qx, qy, ex, ey);
      ident = is_ident(P_BIG, px, py, qx, qy);
      run_big(px, py, qx, qy, rx, ry, lat, seen);
      checks++;
      if (!seen || (ident && lat != 3) || lat > BOUND_B) begin
        failures++;
        $display("FAIL rand_secp_lat n=%0d got lat=%0d done=%b", n, lat, seen);
      end
      checks++;
      if (rx !== ex || ry !== ey) begin
        failures++;
        $display("FAIL rand_secp n=%0d got %h,%h expected %h,%h", n, rx, ry, ex, ey);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (done_b !== 1'b1 || r_b !== {ex, ey}) begin
        failures++;
        $display("FAIL rand_secp_hold n=%0d Done=%b R=%h", n, done_b, r_b);
      end
    end
  endtask

  initial begin
    rst_s = 1'b0;  rst_b = 1'b0;
    p_s = '0;  q_s = '0;  p_b = '0;  q_b = '0;
    test_reset();
    test_general_add();
    test_doubling();
    test_inverse_identity();
    test_reset_midop();
    test_random_small();
    test_secp_fixed();
    test_secp_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
